// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// APB3 initiator. Takes one command at a time from a valid/ready command
// channel, runs a SETUP/ACCESS transfer on the APB bus, and returns read data
// and error status on a valid/ready response channel.
//
// Optional feature: define APB_TIMEOUT_EN to enable an ACCESS-phase watchdog.
// The watchdog aborts a transfer after TIMEOUT ACCESS cycles without pready.
// Without the macro, ACCESS waits for pready indefinitely and rsp_timeout is
// tied low.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for cmd_valid
// SETUP  | psel=1, penable=0, lasts exactly one cycle
// ACCESS | psel=1, penable=1, waits for pready (or for the watchdog)
// RESP   | bus released, rsp_valid held until rsp_ready

module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              m_apb_psel,
    output logic              m_apb_penable,
    output logic              m_apb_pwrite,
    output logic [ADDR_W-1:0] m_apb_paddr,
    output logic [DATA_W-1:0] m_apb_pwdata,
    input  logic              m_apb_pready,
    input  logic [DATA_W-1:0] m_apb_prdata,
    input  logic              m_apb_pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state;

`ifdef APB_TIMEOUT_EN
    // The counter only needs to reach TIMEOUT-1: that is the last ACCESS
    // cycle in which pready can still complete the transfer normally.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             to_flag;

    assign rsp_timeout = to_flag;
`else
    assign rsp_timeout = 1'b0;
`endif

    // The only combinational output: the bridge accepts exactly when idle.
    assign cmd_ready = (state == S_IDLE);

    // Transfer sequencer with all bus and response outputs registered.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state         <= S_IDLE;
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            m_apb_pwrite  <= 1'b0;
            m_apb_paddr   <= '0;
            m_apb_pwdata  <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
`ifdef APB_TIMEOUT_EN
            to_cnt        <= '0;
            to_flag       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // Address/data/direction are only reloaded here, so they
                    // stay stable through SETUP and ACCESS and are held
                    // afterwards until the next accept.
                    if (cmd_valid) begin
                        m_apb_pwrite <= cmd_write;
                        m_apb_paddr  <= cmd_addr;
                        m_apb_pwdata <= cmd_wdata;
                        m_apb_psel   <= 1'b1;
                        state        <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    m_apb_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    to_cnt        <= '0;
`endif
                    state         <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (m_apb_pready) begin
                        // Writes return zero regardless of what the slave
                        // leaves on prdata.
                        rsp_rdata     <= m_apb_pwrite ? '0 : m_apb_prdata;
                        rsp_err       <= m_apb_pslverr;
`ifdef APB_TIMEOUT_EN
                        to_flag       <= 1'b0;
`endif
                        rsp_valid     <= 1'b1;
                        m_apb_psel    <= 1'b0;
                        m_apb_penable <= 1'b0;
                        state         <= S_RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (to_cnt == CNT_LAST) begin
                        rsp_rdata     <= '0;
                        rsp_err       <= 1'b1;
                        to_flag       <= 1'b1;
                        rsp_valid     <= 1'b1;
                        m_apb_psel    <= 1'b0;
                        m_apb_penable <= 1'b0;
                        state         <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    m_apb_psel    <= 1'b0;
                    m_apb_penable <= 1'b0;
                    rsp_valid     <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Drives apb_master_bridge with directed and random transfers. A slave model
// with its own memory answers the APB side; a separate reference memory,
// updated from the command stream, predicts every response.
`timescale 1ns/1ps

module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          m_apb_psel;
    logic          m_apb_penable;
    logic          m_apb_pwrite;
    logic [AW-1:0] m_apb_paddr;
    logic [DW-1:0] m_apb_pwdata;
    logic          m_apb_pready = 1'b0;
    logic [DW-1:0] m_apb_prdata = '0;
    logic          m_apb_pslverr = 1'b0;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_          (rst_),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .rsp_timeout   (rsp_timeout),
        .m_apb_psel    (m_apb_psel),
        .m_apb_penable (m_apb_penable),
        .m_apb_pwrite  (m_apb_pwrite),
        .m_apb_paddr   (m_apb_paddr),
        .m_apb_pwdata  (m_apb_pwdata),
        .m_apb_pready  (m_apb_pready),
        .m_apb_prdata  (m_apb_prdata),
        .m_apb_pslverr (m_apb_pslverr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic logic [31:0] slv_read(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : (a ^ 32'hC0DE_0000);
    endfunction

    // One complete transfer, entered and left at a negedge with the bridge idle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic err, input int rsp_wait,
                        input logic hold, input logic chk_period);
        logic        abort;
        int          n_acc;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        exp_to;
        abort = 1'b0;
`ifdef APB_TIMEOUT_EN
        abort = (waits >= TO);
`endif
        n_acc = abort ? TO : waits + 1;
        if (abort) begin
            exp_rd = 32'h0; exp_err = 1'b1; exp_to = 1'b1;
        end else begin
            exp_rd  = wr ? 32'h0 : ref_read(addr);
            exp_err = err;
            exp_to  = 1'b0;
            if (wr && !err) ref_mem[addr] = wdata;
        end

        check("idle_cmd_ready", cmd_ready, 1);
        if (chk_period) check("cmd_period", cyc - last_acc, 4);
        last_acc = cyc;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(negedge clk);

        check("setup_psel", m_apb_psel, 1);
        check("setup_penable", m_apb_penable, 0);
        check("setup_paddr", m_apb_paddr, addr);
        check("setup_pwrite", m_apb_pwrite, wr);
        if (wr) check("setup_pwdata", m_apb_pwdata, wdata);
        check("setup_cmd_ready", cmd_ready, 0);
        check("setup_rsp_valid", rsp_valid, 0);
        // junk command while busy must be ignored
        cmd_valid = hold ? 1'b1 : 1'($urandom);
        cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        @(negedge clk);

        for (int w = 0; w < n_acc; w++) begin
            check("acc_psel", m_apb_psel, 1);
            check("acc_penable", m_apb_penable, 1);
            check("acc_paddr", m_apb_paddr, addr);
            check("acc_pwrite", m_apb_pwrite, wr);
            if (wr) check("acc_pwdata", m_apb_pwdata, wdata);
            check("acc_rsp_valid", rsp_valid, 0);
            check("acc_cmd_ready", cmd_ready, 0);
            if (!abort && w == waits) begin
                m_apb_pready  = 1'b1;
                m_apb_pslverr = err;
                m_apb_prdata  = wr ? $urandom : slv_read(m_apb_paddr);
                if (wr && !err) slv_mem[m_apb_paddr] = m_apb_pwdata;
            end else begin
                m_apb_pready  = 1'b0;
                m_apb_pslverr = 1'($urandom);
                m_apb_prdata  = $urandom;
            end
            @(negedge clk);
        end
        m_apb_pready = 1'b0; m_apb_pslverr = 1'b0; m_apb_prdata = $urandom;

        for (int r = 0; r <= rsp_wait; r++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_psel", m_apb_psel, 0);
            check("rsp_penable", m_apb_penable, 0);
            check("rsp_cmd_ready", cmd_ready, 0);
            check("rsp_err", rsp_err, exp_err);
            check("rsp_timeout", rsp_timeout, exp_to);
            check("rsp_rdata", rsp_rdata, exp_rd);
            rsp_ready = hold || (r == rsp_wait);
            @(negedge clk);
        end
        rsp_ready = hold;
        check("end_cmd_ready", cmd_ready, 1);
        check("end_rsp_valid", rsp_valid, 0);
        check("end_psel", m_apb_psel, 0);
        cmd_valid = hold;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", m_apb_psel, 0);
        check("rst_penable", m_apb_penable, 0);
        check("rst_pwrite", m_apb_pwrite, 0);
        check("rst_paddr", m_apb_paddr, 0);
        check("rst_pwdata", m_apb_pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);

        // 1: zero-wait write
        xfer(1'b1, 32'h10, 32'hA5A5_5A5A, 0, 1'b0, 0, 1'b0, 1'b0);
        // 2: read with 3 wait states
        slv_mem[32'h14] = 32'h1234_5678;
        ref_mem[32'h14] = 32'h1234_5678;
        xfer(1'b0, 32'h14, 32'h0, 3, 1'b0, 0, 1'b0, 1'b0);
        // 3: write with slave error, response stalled 5 cycles
        xfer(1'b1, 32'h18, 32'hDEAD_BEEF, 0, 1'b1, 5, 1'b0, 1'b0);
        xfer(1'b0, 32'h18, 32'h0, 1, 1'b0, 0, 1'b0, 1'b0);

        // 4a: reset during ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h14;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_penable", m_apb_penable, 1);
        #2 rst_ = 1'b0;
        #1;
        check("async_rst_psel", m_apb_psel, 0);
        check("async_rst_penable", m_apb_penable, 0);
        check("async_rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_ = 1'b1;
        // 4b: reset while a response is pending
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h14;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        m_apb_pready = 1'b1; m_apb_prdata = 32'h5555_AAAA;
        @(negedge clk);
        m_apb_pready = 1'b0;
        check("pre_rst_rsp_valid", rsp_valid, 1);
        #2 rst_ = 1'b0;
        #1;
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        xfer(1'b0, 32'h14, 32'h0, 0, 1'b0, 0, 1'b0, 1'b0);

        // 5: pready stuck low (abort with watchdog, else completes after 110)
        xfer(1'b0, 32'h1C, 32'h0, 110, 1'b0, 0, 1'b0, 1'b0);
        // pready in the last allowed cycle completes normally
        xfer(1'b0, 32'h10, 32'h0, TO - 1, 1'b0, 1, 1'b0, 1'b0);
        xfer(1'b1, 32'h20, 32'h0BAD_F00D, TO, 1'b0, 0, 1'b0, 1'b0);
        xfer(1'b0, 32'h20, 32'h0, 0, 1'b0, 0, 1'b0, 1'b0);

        // 6: back-to-back commands, one every 4 cycles
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        xfer(1'b1, 32'h24, 32'h1111_0001, 0, 1'b0, 0, 1'b1, 1'b0);
        xfer(1'b1, 32'h28, 32'h2222_0002, 0, 1'b0, 0, 1'b1, 1'b1);
        xfer(1'b0, 32'h24, 32'h0, 0, 1'b0, 0, 1'b1, 1'b1);
        xfer(1'b0, 32'h28, 32'h0, 0, 1'b0, 0, 1'b1, 1'b1);
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);

        // random traffic over a small address window
        for (int i = 0; i < 40; i++) begin
            logic        wr;
            logic [31:0] a;
            wr = 1'($urandom);
            a  = 32'h10 + {27'h0, 3'($urandom), 2'b00};
            xfer(wr, a, $urandom, int'($urandom_range(0, 4)),
                 ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
